pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255, is the maximum number of MEM_WAIT cycles before abort; legal range 1..255.
REQ-002 The ports SHALL be as follows; clock and reset are listed first:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- hdu_stall  in  1  load-use hazard request from the hazard detection unit.
- br_taken  in  1  EX-stage branch/jump redirect.
- mem_req  in  1  EX/MEM stage data-memory access in progress.
- mem_ready  in  1  data-memory acknowledge.
- pc_en  out  1  PC register write enable.
- if_id_en  out  1  IF/ID register write enable.
- if_id_flush  out  1  IF/ID register clear to NOP.
- id_ex_en  out  1  ID/EX register write enable.
- id_ex_flush  out  1  ID/EX register clear to bubble.
- ex_mem_en  out  1  EX/MEM and MEM/WB register write enable.
- bus_err  out  1  one-cycle pulse on memory timeout.
- perf_stall_cnt  out  32  count of cycles with pc_en=0.

Function
REQ-003 The state register SHALL hold exactly four states: RUN, MEM_WAIT, FLUSH, LOAD_USE.
REQ-004 Outputs SHALL be combinational (Mealy) from the current state and inputs, with zero-cycle latency from a request to its effect; the state and counters SHALL be registered.
REQ-005 Default output values (RUN, no request): pc_en, if_id_en, id_ex_en and ex_mem_en =1; flushes and bus_err =0.
REQ-006 Request priority SHALL be, highest first: memory freeze (mem_req=1 and mem_ready=0), then br_taken, then hdu_stall.
REQ-007 Memory freeze behaviour:
- All four enables =0 and both flushes =0.
- Next state MEM_WAIT; the wait counter loads 1.
REQ-008 MEM_WAIT behaviour:
- The freeze holds while mem_ready=0, and the wait counter increments each cycle.
- On mem_ready=1: enables =1 that cycle, and the next state is RUN.
- On count reaching MEM_TIMEOUT with mem_ready=0: bus_err=1 for that one cycle, enables =1, next state RUN.
REQ-009 Branch behaviour (no freeze, br_taken=1):
- pc_en=1, if_id_flush=1, id_ex_flush=1.
- Next state FLUSH.
REQ-010 FLUSH behaviour:
- Lasts exactly one cycle; hdu_stall is ignored during it, because ID holds a flushed NOP.
- br_taken and freeze are honoured normally.
- Otherwise the next state is RUN.
REQ-011 Load-use behaviour (RUN or LOAD_USE, no freeze, no branch, hdu_stall=1):
- pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1.
- Next state LOAD_USE.
REQ-012 LOAD_USE SHALL return to RUN on the first cycle hdu_stall=0; back-to-back stalls remain in LOAD_USE without a limit.
REQ-013 Flush outputs SHALL take precedence over the enables at the consuming register; pipe_ctrl SHALL never assert a flush with the matching enable =0 except id_ex_flush during load-use.
REQ-014 The wait counter SHALL be 8 bits, cleared on every exit from MEM_WAIT, and SHALL never wrap.

Reset
REQ-015 While rst=1: state=RUN, wait counter=0, perf_stall_cnt=0, and bus_err=0.
REQ-016 All enables SHALL read 0 while rst=1, and both flushes SHALL read 1.
REQ-017 Reset asserted mid-MEM_WAIT or mid-LOAD_USE SHALL abort immediately with no bus_err pulse.
REQ-018 The first edge after deassertion SHALL evaluate from RUN.

Configuration
REQ-019 Macro PIPE_STALL_CNT_EN SHALL control the stall counter:
- Defined: perf_stall_cnt increments by 1 on each clock edge where pc_en=0 and rst=0, and wraps 0xFFFFFFFF->0.
- Undefined: perf_stall_cnt is constant 0 and no counter flops are inferred.
- All other behaviour is identical in both builds.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Load-use: hdu_stall=1 for 1 cycle in RUN -> pc_en=0, if_id_en=0, id_ex_flush=1 that cycle; next cycle all enables=1.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles then 1 -> enables=0 for 3 cycles, =1 on the 4th; perf_stall_cnt=3 with the macro defined, 0 without.
- Timeout: MEM_TIMEOUT=4, mem_ready stuck 0 -> bus_err single pulse on the 4th freeze cycle; state RUN after.
- Priority: br_taken=1 and hdu_stall=1 together -> pc_en=1, both flushes=1; next cycle hdu_stall=1 ignored (pc_en=1); the following cycle it is honoured.
- Freeze over branch: mem_req=1, mem_ready=0 and br_taken=1 -> all enables=0, flushes=0.
- Reset mid-MEM_WAIT after 2 cycles -> enables=0 and flushes=1 during rst, no bus_err, RUN after; counter wraps 0xFFFFFFFF->0 (force preload).

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: memory freeze, branch flush, load-use stall.
// Optional stall-cycle counter enabled by defining PIPE_STALL_CNT_EN.
module pipe_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hdu_stall,
  input  logic        br_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        if_id_flush,
  output logic        id_ex_en,
  output logic        id_ex_flush,
  output logic        ex_mem_en,
  output logic        bus_err,
  output logic [31:0] perf_stall_cnt
);

  // state    | meaning
  // RUN      | normal issue
  // MEM_WAIT | pipeline frozen on an outstanding data-memory access
  // FLUSH    | one cycle after a redirect; ID holds a NOP
  // LOAD_USE | bubble inserted into EX while the load result is pending
  typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH, LOAD_USE} state_t;

  // The first freeze cycle is spent in RUN, so the last allowed wait count is one less.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d     = RUN;
    wait_d      = 8'd0;
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_en    = 1'b1;
    id_ex_flush = 1'b0;
    ex_mem_en   = 1'b1;
    bus_err     = 1'b0;

    if (rst) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      ex_mem_en   = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (state_q == MEM_WAIT) begin
      if (mem_ready) begin
        state_d = RUN;
      end else if (wait_q >= WAIT_LAST) begin
        bus_err = 1'b1;
        state_d = RUN;
      end else begin
        pc_en     = 1'b0;
        if_id_en  = 1'b0;
        id_ex_en  = 1'b0;
        ex_mem_en = 1'b0;
        state_d   = MEM_WAIT;
        wait_d    = wait_q + 8'd1;
      end
    end else if (mem_req && !mem_ready) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      state_d   = MEM_WAIT;
      wait_d    = 8'd1;
    end else if (br_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      state_d     = FLUSH;
    end else if (hdu_stall && state_q != FLUSH) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      id_ex_flush = 1'b1;
      state_d     = LOAD_USE;
    end
  end

`ifdef PIPE_STALL_CNT_EN
  logic [31:0] perf_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      perf_cnt_q <= 32'd0;
    else if (!pc_en)
      perf_cnt_q <= perf_cnt_q + 32'd1;
  end

  assign perf_stall_cnt = perf_cnt_q;
`else
  assign perf_stall_cnt = 32'd0;
`endif

endmodule
